// File: rtl/lfsr_counter_gen.sv
// Fibonacci LFSR counter with programmable taps, seed load, lock-up guard,
// match detect and period measurement. Define LFSR_REVERSE_EN to add the dir port.
module lfsr_counter_gen #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   TAPS      = {1'b1, {WIDTH-2{1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0]   RESET_VAL = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             load_n,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] match_val,
`ifdef LFSR_REVERSE_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] steps,
    output logic [WIDTH-1:0] period,
    output logic             wrap,
    output logic             match,
    output logic             load_err
);

    logic [WIDTH-1:0] seed_r;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] seed_nxt;
    logic [WIDTH-1:0] steps_nxt;
    logic [WIDTH-1:0] period_nxt;
    logic             wrap_nxt;
    logic             err_nxt;
    logic [WIDTH-1:0] stepped;

    function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] c);
        return {^(c & TAPS), c[WIDTH-1:1]};
    endfunction

    // Exact inverse of step_fwd: recover the bit that was shifted out (TAPS[0] is 1).
    function automatic logic [WIDTH-1:0] step_rev(input logic [WIDTH-1:0] c);
        return {c[WIDTH-2:0], c[WIDTH-1] ^ (^(c[WIDTH-2:0] & TAPS[WIDTH-1:1]))};
    endfunction

`ifdef LFSR_REVERSE_EN
    assign stepped = dir ? step_rev(count) : step_fwd(count);
`else
    assign stepped = step_fwd(count);
`endif

    always_comb begin
        count_nxt  = count;
        seed_nxt   = seed_r;
        steps_nxt  = steps;
        period_nxt = period;
        wrap_nxt   = 1'b0;
        err_nxt    = 1'b0;
        if (!load_n) begin
            steps_nxt = '0;
            if (data != '0) begin
                count_nxt = data;
                seed_nxt  = data;
            end else begin
                count_nxt = RESET_VAL;
                seed_nxt  = RESET_VAL;
                err_nxt   = 1'b1;
            end
        end else if (count == '0) begin
            // Safeguard only: zero is unreachable, but never stay locked up.
            count_nxt = RESET_VAL;
            seed_nxt  = RESET_VAL;
            steps_nxt = '0;
            err_nxt   = 1'b1;
        end else if (cen) begin
            count_nxt = stepped;
            if (stepped == seed_r) begin
                wrap_nxt   = 1'b1;
                period_nxt = steps + WIDTH'(1);
                steps_nxt  = '0;
            end else begin
                steps_nxt = steps + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= RESET_VAL;
            seed_r   <= RESET_VAL;
            steps    <= '0;
            period   <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            seed_r   <= seed_nxt;
            steps    <= steps_nxt;
            period   <= period_nxt;
            wrap     <= wrap_nxt;
            load_err <= err_nxt;
        end
    end

    // match follows match_val, so it cannot be an async-reset constant; while
    // rst is held it is recomputed against RESET_VAL on each clock edge.
    always_ff @(posedge clk) begin
        match <= ((rst ? RESET_VAL : count_nxt) == match_val);
    end

endmodule

// File: tb/tb_lfsr_counter_gen.sv
// Self-checking bench for lfsr_counter_gen (WIDTH=4, TAPS=1001, RESET_VAL=1),
// directed scenarios plus randomized traffic against a behavioural model.
module tb_lfsr_counter_gen;
    localparam int         W  = 4;
    localparam logic [3:0] TP = 4'b1001;
    localparam logic [3:0] RV = 4'd1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       load_n = 1'b1;
    logic [3:0] data = 4'd0;
    logic [3:0] match_val = 4'd0;
    logic       dir = 1'b0;
    logic [3:0] count, steps, period;
    logic       wrap, match, load_err;

    int total = 0;
    int bad   = 0;

    logic [3:0] m_count, m_seed, m_steps, m_period;
    logic       m_wrap, m_err, m_match;

    lfsr_counter_gen #(.WIDTH(W), .TAPS(TP), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .cen(cen), .load_n(load_n), .data(data),
        .match_val(match_val),
`ifdef LFSR_REVERSE_EN
        .dir(dir),
`endif
        .count(count), .steps(steps), .period(period), .wrap(wrap),
        .match(match), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Feedback is the parity of the tapped bits, shifted in at the top.
    function automatic logic [3:0] m_fwd(input logic [3:0] c);
        int par = 0;
        for (int i = 0; i < 4; i++)
            if (TP[i] && c[i]) par = par ^ 1;
        return (c >> 1) | 4'(par << 3);
    endfunction

    // Reverse step = the unique state whose forward step lands on c.
    function automatic logic [3:0] m_pred(input logic [3:0] c);
        for (int v = 0; v < 16; v++)
            if (m_fwd(4'(v)) == c) return 4'(v);
        return 4'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_count = RV; m_seed = RV; m_steps = 0; m_period = 0;
        m_wrap = 0; m_err = 0; m_match = (RV == match_val);
    endtask

    task automatic model_step(input logic ld_n, input logic ce, input logic [3:0] d,
                              input logic [3:0] mv, input logic rv);
        logic [3:0] n;
        m_wrap = 0;
        m_err  = 0;
        if (!ld_n) begin
            m_steps = 0;
            if (d == 0) begin m_count = RV; m_seed = RV; m_err = 1; end
            else begin m_count = d; m_seed = d; end
        end else if (ce) begin
            n = rv ? m_pred(m_count) : m_fwd(m_count);
            if (n == m_seed) begin
                m_wrap = 1; m_period = 4'((m_steps + 1) % 16); m_steps = 0;
            end else begin
                m_steps = 4'((m_steps + 1) % 16);
            end
            m_count = n;
        end
        m_match = (m_count == mv);
    endtask

    task automatic do_reset();
        rst = 1; cen = 0; load_n = 1; data = 0; dir = 0;
        tick();
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1; cen = 1; load_n = 1; match_val = RV;
        tick(); tick();
        total++; if (count !== RV) begin bad++; $display("FAIL rst_count got=%h want=%h", count, RV); end
        total++; if (steps !== 4'd0) begin bad++; $display("FAIL rst_steps got=%h want=0", steps); end
        total++; if (period !== 4'd0) begin bad++; $display("FAIL rst_period got=%h want=0", period); end
        total++; if (wrap !== 1'b0 || load_err !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b want=00", wrap, load_err); end
        total++; if (match !== 1'b1) begin bad++; $display("FAIL rst_match_hi got=%b want=1", match); end
        match_val = 4'd5;
        tick();
        total++; if (match !== 1'b0) begin bad++; $display("FAIL rst_match_lo got=%b want=0", match); end
        rst = 0; cen = 0;
    endtask

    task automatic test_count4();
        logic [3:0] exp_c [4] = '{4'h8, 4'hC, 4'hE, 4'hF};
        do_reset();
        total++; if (count !== 4'h1) begin bad++; $display("FAIL cnt4_start got=%h want=1", count); end
        cen = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (count !== exp_c[i]) begin bad++; $display("FAIL cnt4_count[%0d] got=%h want=%h", i, count, exp_c[i]); end
            total++; if (steps !== 4'(i + 1)) begin bad++; $display("FAIL cnt4_steps[%0d] got=%0d want=%0d", i, steps, i + 1); end
        end
        cen = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        cen = 1;
        for (int i = 1; i < 15; i++) begin
            tick();
            total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_early[%0d] got=%b want=0", i, wrap); end
        end
        tick();
        total++; if (wrap !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%b want=1", wrap); end
        total++; if (count !== 4'h1) begin bad++; $display("FAIL wrap_count got=%h want=1", count); end
        total++; if (period !== 4'd15) begin bad++; $display("FAIL wrap_period got=%0d want=15", period); end
        total++; if (steps !== 4'd0) begin bad++; $display("FAIL wrap_steps got=%0d want=0", steps); end
        tick();
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_single got=%b want=0", wrap); end
        total++; if (period !== 4'd15) begin bad++; $display("FAIL wrap_period_hold got=%0d want=15", period); end
        cen = 0;
    endtask

    task automatic test_load_zero();
        cen = 0; load_n = 0; data = 4'd0;
        tick();
        total++; if (count !== 4'h1) begin bad++; $display("FAIL ldz_count got=%h want=1", count); end
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL ldz_err got=%b want=1", load_err); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ldz_wrap got=%b want=0", wrap); end
        load_n = 1;
        tick();
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL ldz_err_single got=%b want=0", load_err); end
        load_n = 0; data = 4'b0110; cen = 1;
        tick();
        total++; if (count !== 4'b0110) begin bad++; $display("FAIL ld6_count got=%h want=6", count); end
        total++; if (steps !== 4'd0) begin bad++; $display("FAIL ld6_steps got=%0d want=0", steps); end
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL ld6_err got=%b want=0", load_err); end
        load_n = 1; cen = 0;
    endtask

    task automatic test_match();
        logic exp_m [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        match_val = 4'hE;
        do_reset();
        total++; if (match !== 1'b0) begin bad++; $display("FAIL match_rst got=%b want=0", match); end
        cen = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (match !== exp_m[i]) begin bad++; $display("FAIL match[%0d] got=%b want=%b", i, match, exp_m[i]); end
        end
        cen = 0;
        match_val = count;
        total++; if (match !== 1'b0) begin bad++; $display("FAIL match_lag got=%b want=0", match); end
        tick();
        total++; if (match !== 1'b1) begin bad++; $display("FAIL match_late got=%b want=1", match); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cen = 1;
        for (int i = 0; i < 19; i++) tick();
        total++; if (count !== 4'hF || steps !== 4'd4 || period !== 4'd15) begin
            bad++; $display("FAIL mid_pre got=%h/%0d/%0d want=f/4/15", count, steps, period); end
        #2 rst = 1;
        #1;
        total++; if (count !== 4'h1) begin bad++; $display("FAIL mid_count got=%h want=1", count); end
        total++; if (steps !== 4'd0 || period !== 4'd0) begin bad++; $display("FAIL mid_steps_period got=%0d/%0d want=0/0", steps, period); end
        rst = 0; cen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (count !== 4'h1 || steps !== 4'd0 || period !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0) begin
                bad++; $display("FAIL mid_hold[%0d] got=%h/%0d/%0d/%b/%b want=1/0/0/0/0", i, count, steps, period, wrap, load_err); end
        end
    endtask

`ifdef LFSR_REVERSE_EN
    task automatic test_reverse();
        do_reset();
        cen = 1; dir = 0;
        tick();
        total++; if (count !== 4'h8) begin bad++; $display("FAIL rev_pre got=%h want=8", count); end
        dir = 1;
        tick();
        total++; if (count !== 4'h1 || wrap !== 1'b1) begin bad++; $display("FAIL rev_step got=%h/%b want=1/1", count, wrap); end
        dir = 0;
        tick();
        total++; if (count !== 4'h8 || wrap !== 1'b0) begin bad++; $display("FAIL rev_fwd got=%h/%b want=8/0", count, wrap); end
        cen = 0;
    endtask
`endif

    task automatic test_random();
        logic rdir;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            load_n    = ($urandom_range(0, 15) != 0);
            cen       = ($urandom_range(0, 3) != 0);
            data      = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            match_val = 4'($urandom);
`ifdef LFSR_REVERSE_EN
            dir = ($urandom_range(0, 3) == 0);
            rdir = dir;
`else
            rdir = 1'b0;
`endif
            model_step(load_n, cen, data, match_val, rdir);
            tick();
            total++; if (count !== m_count) begin bad++; $display("FAIL rnd_count[%0d] got=%h want=%h", i, count, m_count); end
            total++; if (steps !== m_steps) begin bad++; $display("FAIL rnd_steps[%0d] got=%0d want=%0d", i, steps, m_steps); end
            total++; if (period !== m_period) begin bad++; $display("FAIL rnd_period[%0d] got=%0d want=%0d", i, period, m_period); end
            total++; if (wrap !== m_wrap || load_err !== m_err) begin bad++; $display("FAIL rnd_pulses[%0d] got=%b%b want=%b%b", i, wrap, load_err, m_wrap, m_err); end
            total++; if (match !== m_match) begin bad++; $display("FAIL rnd_match[%0d] got=%b want=%b", i, match, m_match); end
        end
        cen = 0; load_n = 1;
    endtask

    initial begin
        test_reset();
        test_count4();
        test_wrap();
        test_load_zero();
        test_match();
        test_reset_mid();
`ifdef LFSR_REVERSE_EN
        test_reverse();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lfsr_counter_gen.md
# lfsr_counter_gen

Parametrised Fibonacci LFSR counter with a programmable feedback polynomial, seed load, lock-up protection, match detection and period measurement. It is the general-purpose successor to the fixed 2-tap LFSR counter. It is intended for pseudo-random sequencing, test-pattern generation and compact terminal-count timers. All outputs are registered in a single clock domain.

## Interface

- WIDTH, 4, register width in bits; legal range 3..32.
- TAPS, {1'b1,{WIDTH-2{1'b0}},1'b1}, feedback mask (WIDTH bits). Bit k set means count[k] feeds the XOR. TAPS[0] must be 1.
- RESET_VAL, 1, value loaded on reset and on a rejected seed. Must be non-zero.

- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- cen  input  1  count enable; one LFSR step per cycle while high
- load_n  input  1  active-low synchronous seed load
- data  input  WIDTH  seed value, sampled when load_n=0
- match_val  input  WIDTH  compare value
- dir  input  1  0 = forward, 1 = reverse; present only with LFSR_REVERSE_EN
- count  output  WIDTH  current LFSR state
- steps  output  WIDTH  steps taken since the last reset, load or wrap
- period  output  WIDTH  length of the last completed cycle
- wrap  output  1  one-cycle pulse when count returns to the seed
- match  output  1  high while count == match_val
- load_err  output  1  one-cycle pulse when an all-zero seed was rejected

## Operation

- Forward step: fb = ^(count & TAPS); next count = {fb, count[WIDTH-1:1]}.
- Reverse step (dir=1): next count = {count[WIDTH-2:0], c0}, where c0 = count[WIDTH-1] ^ ^(count[WIDTH-2:0] & TAPS[WIDTH-1:1]). This is the exact inverse of the forward step.
- Internal register seed_r holds the last accepted seed. It is RESET_VAL after reset.
- Priority is rst, then load_n=0, then cen=1, then hold.
  - rst=1: count=RESET_VAL, seed_r=RESET_VAL, steps=0, period=0, wrap=0, load_err=0.
  - match is recomputed from RESET_VAL and match_val.
- Load (load_n=0, any cen):
  - If data != 0: count=data, seed_r=data, steps=0.
  - If data == 0: count=RESET_VAL, seed_r=RESET_VAL, steps=0, load_err=1 for one cycle.
  - period is left unchanged. wrap=0.
- Step (load_n=1, cen=1):
  - count advances one step.
  - If the new count == seed_r: wrap=1 for one cycle, period=steps+1, steps=0.
  - Otherwise steps=steps+1, modulo 2^WIDTH.
- Hold (cen=0): all state is held. wrap and load_err are 0.
- Lock-up: all-zero is unreachable by construction, because loads of zero are rejected and the step function is a bijection. As a safeguard, if count is ever observed as 0, the next cycle forces RESET_VAL and pulses load_err, regardless of cen.
- match is registered. It is computed from the next count and the current match_val, so it aligns with count.
  - A change on match_val alone takes effect one cycle later.

## Timing

- Every output changes only on the rising clk edge, or asynchronously on assertion of rst.
- Latency is one cycle from a cen or load_n sample to the updated count, steps, wrap, match and load_err.
- wrap and load_err are single-cycle pulses. They never assert in the same cycle.
- Reset asserted mid-sequence: outputs take their reset values immediately (asynchronously). Counting resumes on the first clock edge after rst is released with cen=1.
- With maximal-length TAPS, wrap recurs every 2^WIDTH-1 steps.
- With non-maximal TAPS, period reports the actual cycle length of the loaded seed's orbit.

## Configuration

- LFSR_REVERSE_EN defined: the dir port exists and dir=1 selects reverse stepping.
  - steps still increments on every step.
  - wrap and period apply in both directions.
- LFSR_REVERSE_EN undefined: the dir port and reverse logic are absent, and every step is forward.

## Test plan

All cases use WIDTH=4, TAPS=4'b1001, RESET_VAL=1.

- Reset, then cen=1 for 4 cycles -> count 0001, 1000, 1100, 1110, 1111; steps 0..4.
- Reset, then cen=1 for 15 cycles -> wrap pulses on cycle 15 with count=0001, period=15, steps=0.
- load_n=0, data=0000 -> count=0001, load_err=1 for one cycle. Then load_n=0, data=0110 with cen=1 -> count=0110, steps=0, no step taken.
- match_val=1110, reset, cen=1 -> match high only in the cycle where count=1110, low on the next step.
- LFSR_REVERSE_EN defined, count=1000, dir=1, cen=1 -> count=0001 and wrap=1 (seed is 0001). A forward step from 0001 returns count to 1000.
- rst asserted mid-count with count=1111 and steps=4 -> count=0001, steps=0, period=0 immediately. cen=0 afterwards -> all outputs hold.
